// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code decoder: make/break tracking, held-key ASCII map, press counter, 6-digit display.
// Optional shift handling is compiled in with `define PS2_SHIFT_EN.
module ps2_scan_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             code_en,
  input  logic [7:0]       code,
  output logic             key_down,
  output logic [7:0]       scan_code,
  output logic [7:0]       ascii,
  output logic [CNT_W-1:0] press_cnt,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3,
  output logic [6:0]       hex4,
  output logic [6:0]       hex5
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BRK  = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} hex glyphs
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Set-2 make code to ASCII; letters are offset from 'a' or 'A' depending on shift
  function automatic logic [7:0] map_ascii(input logic [7:0] c, input logic shift);
    logic [7:0] base;
    logic [7:0] a;
    base = shift ? 8'h41 : 8'h61;
    case (c)
      8'h1C: a = base + 8'd0;
      8'h32: a = base + 8'd1;
      8'h21: a = base + 8'd2;
      8'h23: a = base + 8'd3;
      8'h24: a = base + 8'd4;
      8'h2B: a = base + 8'd5;
      8'h34: a = base + 8'd6;
      8'h33: a = base + 8'd7;
      8'h43: a = base + 8'd8;
      8'h3B: a = base + 8'd9;
      8'h42: a = base + 8'd10;
      8'h4B: a = base + 8'd11;
      8'h3A: a = base + 8'd12;
      8'h31: a = base + 8'd13;
      8'h44: a = base + 8'd14;
      8'h4D: a = base + 8'd15;
      8'h15: a = base + 8'd16;
      8'h2D: a = base + 8'd17;
      8'h1B: a = base + 8'd18;
      8'h2C: a = base + 8'd19;
      8'h3C: a = base + 8'd20;
      8'h2A: a = base + 8'd21;
      8'h1D: a = base + 8'd22;
      8'h22: a = base + 8'd23;
      8'h35: a = base + 8'd24;
      8'h1A: a = base + 8'd25;
      8'h45: a = 8'h30;
      8'h16: a = 8'h31;
      8'h1E: a = 8'h32;
      8'h26: a = 8'h33;
      8'h25: a = 8'h34;
      8'h2E: a = 8'h35;
      8'h36: a = 8'h36;
      8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;
      8'h46: a = 8'h39;
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  state_t           state_q, state_d;
  logic             en_q, en_d;
  logic             en_dly_q, en_dly_d;
  logic [7:0]       code_q, code_d;
  logic             key_down_q, key_down_d;
  logic [7:0]       scan_code_q, scan_code_d;
  logic [7:0]       ascii_q, ascii_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic [6:0]       hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d;
  logic [6:0]       hex3_q, hex3_d, hex4_q, hex4_d, hex5_q, hex5_d;
  logic             evt_s;
  logic             shift_cur_s;
  logic             is_shift_s;
  logic [7:0]       cnt_disp_s;
`ifdef PS2_SHIFT_EN
  logic             shift_q, shift_d;
`endif

  // Input stage is registered, so the edge detect lands one cycle after code_en is sampled
  assign evt_s = en_q & ~en_dly_q;

`ifdef PS2_SHIFT_EN
  assign shift_cur_s = shift_q;
  assign is_shift_s  = (code_q == 8'h12) || (code_q == 8'h59);
`else
  assign shift_cur_s = 1'b0;
  assign is_shift_s  = 1'b0;
`endif

  // Next-state: event detect, make/break FSM, counter, display encode from next-state values
  always_comb begin
    en_d        = code_en;
    en_dly_d    = en_q;
    code_d      = code_q;
    state_d     = state_q;
    key_down_d  = key_down_q;
    scan_code_d = scan_code_q;
    ascii_d     = ascii_q;
    press_cnt_d = press_cnt_q;
`ifdef PS2_SHIFT_EN
    shift_d     = shift_q;
`endif
    if (code_en) begin
      code_d = code;
    end else begin
      code_d = code_q;
    end

    if (evt_s) begin
      case (state_q)
        IDLE: begin
          if (code_q == 8'hF0) begin
            state_d = BRK;
          end else if (code_q == 8'hE0) begin
            state_d = IDLE;
          end else if (is_shift_s) begin
`ifdef PS2_SHIFT_EN
            shift_d = 1'b1;
`endif
          end else if (key_down_q && (code_q == scan_code_q)) begin
            state_d = IDLE;
          end else begin
            scan_code_d = code_q;
            ascii_d     = map_ascii(code_q, shift_cur_s);
            key_down_d  = 1'b1;
            press_cnt_d = press_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        BRK: begin
          state_d = IDLE;
          if (is_shift_s) begin
`ifdef PS2_SHIFT_EN
            shift_d = 1'b0;
`endif
          end else if (code_q == scan_code_q) begin
            key_down_d = 1'b0;
          end else begin
            key_down_d = key_down_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end

    cnt_disp_s = 8'(press_cnt_d);
    if (key_down_d) begin
      hex0_d = seg7(scan_code_d[3:0]);
      hex1_d = seg7(scan_code_d[7:4]);
      hex2_d = seg7(ascii_d[3:0]);
      hex3_d = seg7(ascii_d[7:4]);
    end else begin
      hex0_d = SEG_BLANK;
      hex1_d = SEG_BLANK;
      hex2_d = SEG_BLANK;
      hex3_d = SEG_BLANK;
    end
    hex4_d = seg7(cnt_disp_s[3:0]);
    hex5_d = seg7(cnt_disp_s[7:4]);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      en_q        <= 1'b0;
      en_dly_q    <= 1'b0;
      code_q      <= 8'h00;
      state_q     <= IDLE;
      key_down_q  <= 1'b0;
      scan_code_q <= 8'h00;
      ascii_q     <= 8'h00;
      press_cnt_q <= '0;
      hex0_q      <= SEG_BLANK;
      hex1_q      <= SEG_BLANK;
      hex2_q      <= SEG_BLANK;
      hex3_q      <= SEG_BLANK;
      hex4_q      <= 7'h40;
      hex5_q      <= 7'h40;
`ifdef PS2_SHIFT_EN
      shift_q     <= 1'b0;
`endif
    end else begin
      en_q        <= en_d;
      en_dly_q    <= en_dly_d;
      code_q      <= code_d;
      state_q     <= state_d;
      key_down_q  <= key_down_d;
      scan_code_q <= scan_code_d;
      ascii_q     <= ascii_d;
      press_cnt_q <= press_cnt_d;
      hex0_q      <= hex0_d;
      hex1_q      <= hex1_d;
      hex2_q      <= hex2_d;
      hex3_q      <= hex3_d;
      hex4_q      <= hex4_d;
      hex5_q      <= hex5_d;
`ifdef PS2_SHIFT_EN
      shift_q     <= shift_d;
`endif
    end
  end

  assign key_down  = key_down_q;
  assign scan_code = scan_code_q;
  assign ascii     = ascii_q;
  assign press_cnt = press_cnt_q;
  assign hex0      = hex0_q;
  assign hex1      = hex1_q;
  assign hex2      = hex2_q;
  assign hex3      = hex3_q;
  assign hex4      = hex4_q;
  assign hex5      = hex5_q;

endmodule

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Consumes the received-byte stream from the PS/2 receiver (`reg_en` / `to_reg`) and turns raw scan-code bytes into key events. It tracks the make/break (`F0`) sequence, keeps the currently held key, maps it to ASCII and counts distinct key presses. It drives six active-low seven-segment digits for the board display, so it sits between the PS/2 receiver and the top-level pin assignments.

## Interface
- `CNT_W`, default 8: width of the press counter; it is shown as two hex digits, so only `[7:0]` is displayed.
- `clk` input 1: system clock, the same clock as the PS/2 receiver.
- `resetn` input 1: synchronous, active-low reset.
- `code_en` input 1: byte-valid level from the receiver (`reg_en`). It may stay high for many cycles.
- `code` input 8: received byte (`to_reg`). Stable while `code_en` is high.
- `key_down` output 1: a key is currently held.
- `scan_code` output 8: make code of the held key.
- `ascii` output 8: ASCII of the held key; `00` if the key is unmapped.
- `press_cnt` output CNT_W: count of distinct key presses.
- `hex0`..`hex5` output 7 each: active-low segments `{g,f,e,d,c,b,a}`.
  - `hex1:hex0` show `scan_code`.
  - `hex3:hex2` show `ascii`.
  - `hex5:hex4` show `press_cnt[7:0]`.

## Operation
- **Byte event:** `evt = code_en & ~code_en_d`, where `code_en_d` is `code_en` registered.
  - Exactly one event per rising edge of `code_en`, however long the level is held.
  - A repeated identical byte always produces a new event, because the receiver drops `code_en` between frames.
- **State machine** states: `IDLE`, `BRK`.
  - `IDLE`, `code==F0` → `BRK`.
  - `IDLE`, `code==E0` → stay in `IDLE`; the byte is dropped and the next byte is processed normally.
  - `IDLE`, any other code → make handling.
  - `BRK`, any byte → break handling, then `IDLE`.
- **Make handling:**
  - If `key_down==1` and `code==scan_code` (typematic repeat): no change.
  - Otherwise: `scan_code<=code`, `ascii<=map(code)`, `key_down<=1`, `press_cnt<=press_cnt+1`.
- **Break handling:**
  - If `code==scan_code`: `key_down<=0`; `scan_code` and `ascii` hold their values.
  - Otherwise (release of a non-current key): ignored.
- **ASCII map:**
  - Letters `1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A` → `61`..`7A` (a–z in order).
  - Digits `45,16,1E,26,25,2E,36,3D,3E,46` → `30`..`39`.
  - `29` → `20` (space); `5A` → `0D` (enter).
  - Everything else → `00`.
- **Counter:** modulo 2^CNT_W; `FF+1` wraps to `00` when CNT_W=8.
- **Display:**
  - Digits 0–F use standard hex glyphs.
  - `hex0`..`hex3` = `7F` (blank) whenever `key_down==0`.
  - `hex4`/`hex5` are always lit.
- **Reset:** state=`IDLE`, `code_en_d=0`, `key_down=0`, `scan_code=00`, `ascii=00`, `press_cnt=0`, `hex0`..`hex3`=`7F`, `hex4`=`hex5`=`40` (shows "00").
  - Reset asserted mid-sequence (e.g. in `BRK`) discards the pending `F0`.

## Timing
- Every output is registered.
- If `code_en` is first sampled high at clock edge k, the state, `scan_code`, `ascii`, `key_down`, `press_cnt` and all `hexN` outputs reflect the byte after edge k+1 (one cycle latency).
- The segment outputs are registered from the next-state values, so they update in the same cycle as the data outputs.
- No input handshake or backpressure exists. Bytes arrive at least one PS/2 frame apart (thousands of cycles), so no queuing is required.
- `code` is sampled only on the event cycle.

## Configuration
- **`PS2_SHIFT_EN` defined:**
  - Codes `12` and `59` (L/R shift) set a `shift` flag on make and clear it on the matching break. They never change `scan_code`, `key_down` or `press_cnt`.
  - While `shift==1`, letters map to `41`..`5A` (A–Z).
  - `shift` resets to 0.
- **`PS2_SHIFT_EN` undefined:** `12` and `59` are ordinary keys (counted and displayed, ascii `00`). Letters are always lowercase.

## Test plan
- **Single key:** bytes `1C`, `F0`, `1C` → `key_down=1`, `scan_code=1C`, `ascii=61`, `press_cnt=1`, `hex1:hex0` show "1C". After the break: `key_down=0` and `hex0`..`hex3`=`7F`.
- **Typematic and level hold:** `1C` ×4, with the first `code_en` held high for 50 cycles → `press_cnt=1`. Then `F0 1C`, `1C` → `press_cnt=2`.
- **Overlap:** `1C`, `32`, `F0 1C` → `scan_code=32`, `key_down=1`, `press_cnt=2`. Then `F0 32` → `key_down=0`.
- **Wrap:** 256 distinct press/release pairs of `45` → `press_cnt=00` and `ascii=30` on the final press.
- **Reset mid-break:** `1C`, `F0`, pulse `resetn` low for one cycle, then `1C` → counted as a make, `press_cnt=1`, `key_down=1`.
- **Shift (`PS2_SHIFT_EN`):** `12`, `1C` → `ascii=41`, `press_cnt=1`. Then `F0 1C`, `F0 12`, `1C` → `ascii=61`, `press_cnt=2`.
